// File: rtl/lsu_m.sv
// Memory-stage load/store unit: formats stores, aligns/extends loads, drives a req/ready + rvalid data port.
// Latency: store 3 cycles, load 4+ cycles start-to-done; stall_o holds upstream while REQ/RESP is active.
module lsu_m #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_M_i,
  input  logic        flush_i,
  input  logic [31:0] aludata_M_i,
  input  logic [31:0] rs2data_M_i,
  input  logic        wren_M_i,
  input  logic [3:0]  lsop_M_i,
  input  logic        lsuns_M_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ready_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [31:0] lddata_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        buserr_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam int              TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LAST_I);

  state_t          state;
  logic [TO_W-1:0] cnt;
  logic [1:0]      sz;
  logic [1:0]      off;
  logic            uns;

  logic            start;
  logic            mis_start;
  logic [31:0]     st_wdata;
  logic [3:0]      st_be;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [31:0]     ld_fmt;
  logic            unused_op;

  assign unused_op = lsop_M_i[3];

  assign start   = (state == IDLE) & valid_M_i & lsop_M_i[2] & ~flush_i & ~rst_i;
  assign stall_o = start | (state == REQ) | (state == RESP);

  always_comb begin
    mis_start = 1'b0;
    st_wdata  = rs2data_M_i;
    st_be     = 4'b1111;
    case (lsop_M_i[1:0])
      2'b00: begin
        st_wdata = {4{rs2data_M_i[7:0]}};
        st_be    = 4'b0001 << aludata_M_i[1:0];
      end
      2'b01: begin
        mis_start = aludata_M_i[0];
        st_wdata  = {2{rs2data_M_i[15:0]}};
        st_be     = 4'b0011 << aludata_M_i[1:0];
      end
      2'b10:   mis_start = |aludata_M_i[1:0];
      default: mis_start = 1'b1;
    endcase
  end

  // Load lane select uses the offset latched at start, not the live address.
  assign ld_b = dmem_rdata_i[{off, 3'b000} +: 8];
  assign ld_h = dmem_rdata_i[{off[1], 4'b0000} +: 16];

  always_comb begin
    case (sz)
      2'b00:   ld_fmt = uns ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   ld_fmt = uns ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_fmt = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      sz           <= 2'b00;
      off          <= 2'b00;
      uns          <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= 32'b0;
      dmem_wdata_o <= 32'b0;
      dmem_be_o    <= 4'b0;
      lddata_o     <= 32'b0;
      done_o       <= 1'b0;
      misalign_o   <= 1'b0;
      buserr_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sz       <= lsop_M_i[1:0];
            off      <= aludata_M_i[1:0];
            uns      <= lsuns_M_i;
            buserr_o <= 1'b0;
            if (mis_start) begin
              misalign_o <= 1'b1;
              done_o     <= 1'b1;
              state      <= DONE;
            end else begin
              misalign_o   <= 1'b0;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= wren_M_i;
              dmem_addr_o  <= {aludata_M_i[31:2], 2'b00};
              dmem_wdata_o <= st_wdata;
              dmem_be_o    <= wren_M_i ? st_be : 4'b1111;
              state        <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_ready_i) begin
            dmem_req_o <= 1'b0;
            if (dmem_we_o) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              cnt   <= '0;
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (dmem_rvalid_i) begin
            lddata_o <= ld_fmt;
            done_o   <= 1'b1;
            state    <= DONE;
          end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
            buserr_o <= 1'b1;
            lddata_o <= 32'b0;
            done_o   <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_m.sv
// Scoreboard bench for lsu_m: expected completions are queued at start and popped on done_o.
module tb_lsu_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, flush, wren, lsuns;
  logic [31:0] aludata, rs2data;
  logic [3:0]  lsop;
  logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, done, misalign, buserr;
  logic [31:0] lddata;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          vecs = 0;
  int          errs = 0;
  logic [31:0] last_ld = 32'b0;

  lsu_m #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .valid_M_i(valid), .flush_i(flush),
    .aludata_M_i(aludata), .rs2data_M_i(rs2data), .wren_M_i(wren),
    .lsop_M_i(lsop), .lsuns_M_i(lsuns),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_wdata_o(dmem_wdata), .dmem_be_o(dmem_be), .dmem_ready_i(dmem_ready),
    .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .stall_o(stall), .lddata_o(lddata), .done_o(done),
    .misalign_o(misalign), .buserr_o(buserr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [31:0] a, input logic [31:0] d, input logic we,
                             input logic [3:0] op, input logic uns);
    valid = 1'b1; aludata = a; rs2data = d; wren = we; lsop = op; lsuns = uns;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vecs++; if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, lddata, done, misalign, buserr} !== '0) begin errs++; $display("FAIL reset_outputs: got stall=%b req=%b ld=%h done=%b want all zero", stall, dmem_req, lddata, done); end
    @(negedge clk); rst = 1'b0;
    step();
    vecs++; if (stall !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL reset_idle: got stall=%b done=%b want 0 0", stall, done); end
  endtask

  task automatic test_store_byte();
    drive_start(32'h103, 32'h0000_00A5, 1'b1, 4'b0100, 1'b0);
    sb.push_back('{last_ld, 1'b0, 1'b0});
    #1;
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL sb_stall_c1: got %b want 1", stall); end
    step();
    valid = 1'b0; dmem_ready = 1'b1;
    vecs++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall} !== {1'b1, 1'b1, 32'h100, 4'b1000, 32'hA5A5_A5A5, 1'b1}) begin errs++; $display("FAIL sb_req: got req=%b we=%b addr=%h be=%b wdata=%h stall=%b want 1 1 00000100 1000 a5a5a5a5 1", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall); end
    step();
    dmem_ready = 1'b0;
    e = sb.pop_front();
    vecs++; if ({done, stall, dmem_req} !== 3'b100) begin errs++; $display("FAIL sb_done_c3: got done=%b stall=%b req=%b want 1 0 0", done, stall, dmem_req); end
    vecs++; if ({lddata, misalign, buserr} !== {e.ld, e.mis, e.berr}) begin errs++; $display("FAIL sb_result: got ld=%h mis=%b berr=%b want %h %b %b", lddata, misalign, buserr, e.ld, e.mis, e.berr); end
    step();
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL sb_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_store_half_hold();
    drive_start(32'h0000_0402, 32'h1234_ABCD, 1'b1, 4'b0101, 1'b0);
    sb.push_back('{last_ld, 1'b0, 1'b0});
    step();
    valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vecs++; if ({dmem_req, dmem_addr, dmem_be, dmem_wdata, stall} !== {1'b1, 32'h400, 4'b1100, 32'hABCD_ABCD, 1'b1}) begin errs++; $display("FAIL sh_hold%0d: got req=%b addr=%h be=%b wdata=%h want 1 00000400 1100 abcdabcd", i, dmem_req, dmem_addr, dmem_be, dmem_wdata); end
      step();
    end
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    e = sb.pop_front();
    vecs++; if ({done, lddata, misalign, buserr} !== {1'b1, e.ld, e.mis, e.berr}) begin errs++; $display("FAIL sh_result: got done=%b ld=%h mis=%b berr=%b want 1 %h %b %b", done, lddata, misalign, buserr, e.ld, e.mis, e.berr); end
    step();
    drive_start(32'h0000_0804, 32'hCAFE_F00D, 1'b1, 4'b0110, 1'b0);
    step();
    valid = 1'b0; dmem_ready = 1'b1;
    vecs++; if ({dmem_be, dmem_wdata, dmem_addr} !== {4'b1111, 32'hCAFE_F00D, 32'h804}) begin errs++; $display("FAIL sw_req: got be=%b wdata=%h addr=%h want 1111 cafef00d 00000804", dmem_be, dmem_wdata, dmem_addr); end
    step();
    dmem_ready = 1'b0;
    step();
  endtask

  task automatic test_load_half_signed();
    drive_start(32'h202, 32'h0, 1'b0, 4'b0101, 1'b0);
    sb.push_back('{32'hFFFF_8001, 1'b0, 1'b0});
    last_ld = 32'hFFFF_8001;
    step();
    valid = 1'b0; dmem_ready = 1'b1;
    vecs++; if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== {1'b1, 1'b0, 4'b1111, 32'h200}) begin errs++; $display("FAIL lh_req: got req=%b we=%b be=%b addr=%h want 1 0 1111 00000200", dmem_req, dmem_we, dmem_be, dmem_addr); end
    step();
    dmem_ready = 1'b0;
    vecs++; if ({done, stall, dmem_req} !== 3'b010) begin errs++; $display("FAIL lh_resp: got done=%b stall=%b req=%b want 0 1 0", done, stall, dmem_req); end
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_5A5A;
    step();
    dmem_rvalid = 1'b0;
    e = sb.pop_front();
    vecs++; if ({done, stall, lddata, misalign, buserr} !== {1'b1, 1'b0, e.ld, e.mis, e.berr}) begin errs++; $display("FAIL lh_result: got done=%b stall=%b ld=%h want 1 0 %h", done, stall, lddata, e.ld); end
    step();
  endtask

  task automatic test_load_table();
    logic [31:0] a_t[6];
    logic [3:0]  op_t[6];
    logic        u_t[6];
    logic [31:0] rd_t[6];
    logic [31:0] ex_t[6];
    int          cyc;
    a_t[0] = 32'h001; op_t[0] = 4'b0100; u_t[0] = 1'b1; rd_t[0] = 32'h0000_F000; ex_t[0] = 32'h0000_00F0;
    a_t[1] = 32'h001; op_t[1] = 4'b0100; u_t[1] = 1'b0; rd_t[1] = 32'h0000_F000; ex_t[1] = 32'hFFFF_FFF0;
    a_t[2] = 32'h013; op_t[2] = 4'b0100; u_t[2] = 1'b0; rd_t[2] = 32'h7F00_0000; ex_t[2] = 32'h0000_007F;
    a_t[3] = 32'h010; op_t[3] = 4'b0110; u_t[3] = 1'b0; rd_t[3] = 32'hDEAD_BEEF; ex_t[3] = 32'hDEAD_BEEF;
    a_t[4] = 32'h00E; op_t[4] = 4'b0101; u_t[4] = 1'b1; rd_t[4] = 32'h8001_0000; ex_t[4] = 32'h0000_8001;
    a_t[5] = 32'h000; op_t[5] = 4'b1100; u_t[5] = 1'b1; rd_t[5] = 32'h0000_00AB; ex_t[5] = 32'h0000_00AB;
    for (int i = 0; i < 6; i++) begin
      drive_start(a_t[i], 32'h0, 1'b0, op_t[i], u_t[i]);
      sb.push_back('{ex_t[i], 1'b0, 1'b0});
      last_ld = ex_t[i];
      step();
      // Response presented together with ready must be ignored.
      valid = 1'b0; dmem_ready = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
      step();
      dmem_ready = 1'b0; dmem_rdata = rd_t[i];
      step();
      dmem_rvalid = 1'b0;
      wait_done(8, cyc);
      e = sb.pop_front();
      vecs++; if ({done, cyc} !== {1'b1, 32'd0}) begin errs++; $display("FAIL ld%0d_latency: got done=%b extra=%0d want 1 0", i, done, cyc); end
      vecs++; if ({lddata, misalign, buserr} !== {e.ld, e.mis, e.berr}) begin errs++; $display("FAIL ld%0d_data: got %h want %h", i, lddata, e.ld); end
      step();
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] a_t[3];
    logic [3:0]  op_t[3];
    a_t[0] = 32'h006; op_t[0] = 4'b0110;
    a_t[1] = 32'h000; op_t[1] = 4'b0111;
    a_t[2] = 32'h001; op_t[2] = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      drive_start(a_t[i], 32'h0, 1'b0, op_t[i], 1'b0);
      sb.push_back('{last_ld, 1'b1, 1'b0});
      step();
      valid = 1'b0;
      e = sb.pop_front();
      vecs++; if ({dmem_req, done, stall} !== 3'b010) begin errs++; $display("FAIL mis%0d_ctrl: got req=%b done=%b stall=%b want 0 1 0", i, dmem_req, done, stall); end
      vecs++; if ({lddata, misalign, buserr} !== {e.ld, e.mis, e.berr}) begin errs++; $display("FAIL mis%0d_result: got ld=%h mis=%b berr=%b want %h %b %b", i, lddata, misalign, buserr, e.ld, e.mis, e.berr); end
      step();
    end
  endtask

  task automatic test_timeout();
    int cyc;
    drive_start(32'h020, 32'h0, 1'b0, 4'b0110, 1'b0);
    sb.push_back('{32'h0, 1'b0, 1'b1});
    last_ld = 32'h0;
    step();
    valid = 1'b0; dmem_ready = 1'b1;
    vecs++; if (misalign !== 1'b0) begin errs++; $display("FAIL to_mis_clear: got %b want 0", misalign); end
    step();
    dmem_ready = 1'b0;
    wait_done(20, cyc);
    e = sb.pop_front();
    vecs++; if ({done, cyc} !== {1'b1, 32'd4}) begin errs++; $display("FAIL to_cycles: got done=%b resp_cycles=%0d want 1 4", done, cyc); end
    vecs++; if ({lddata, misalign, buserr} !== {e.ld, e.mis, e.berr}) begin errs++; $display("FAIL to_result: got ld=%h mis=%b berr=%b want %h %b %b", lddata, misalign, buserr, e.ld, e.mis, e.berr); end
    step();
    drive_start(32'h030, 32'h5, 1'b1, 4'b0110, 1'b0);
    step();
    valid = 1'b0; dmem_ready = 1'b1;
    vecs++; if (buserr !== 1'b0) begin errs++; $display("FAIL to_berr_clear: got %b want 0", buserr); end
    step();
    dmem_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_resp_and_flush();
    drive_start(32'h040, 32'h0, 1'b0, 4'b0110, 1'b0);
    sb.push_back('{32'h0, 1'b0, 1'b0});
    step();
    valid = 1'b0; dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    void'(sb.pop_front());
    last_ld = 32'h0;
    vecs++; if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, lddata, done, misalign, buserr} !== '0) begin errs++; $display("FAIL rst_resp: got stall=%b req=%b addr=%h be=%b want all zero", stall, dmem_req, dmem_addr, dmem_be); end
    @(negedge clk); rst = 1'b0;
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    step();
    step();
    dmem_rvalid = 1'b0;
    vecs++; if ({done, stall, lddata} !== {1'b0, 1'b0, last_ld}) begin errs++; $display("FAIL rvalid_idle: got done=%b stall=%b ld=%h want 0 0 %h", done, stall, lddata, last_ld); end
    drive_start(32'h050, 32'h0, 1'b0, 4'b0110, 1'b0);
    flush = 1'b1;
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL flush_stall: got %b want 0", stall); end
    step();
    vecs++; if ({dmem_req, done, stall} !== 3'b000) begin errs++; $display("FAIL flush_noreq: got req=%b done=%b stall=%b want 0 0 0", dmem_req, done, stall); end
    flush = 1'b0; valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; flush = 1'b0; wren = 1'b0; lsuns = 1'b0;
    aludata = 32'h0; rs2data = 32'h0; lsop = 4'h0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    test_reset();
    test_store_byte();
    test_store_half_hold();
    test_load_half_signed();
    test_load_table();
    test_misaligned();
    test_timeout();
    test_reset_resp_and_flush();
    vecs++; if (sb.size() != 0) begin errs++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/lsu_m.md
Name: lsu_M

Overview:
- Memory-stage load/store unit. Sits directly downstream of the X/M pipeline register and consumes its M-stage outputs: address (aludata), store data (rs2data), load/store op, unsigned flag and store enable.
- Drives a variable-latency data-memory port with a request/ready handshake and a separate read-response valid.
- Aligns and extends load data, builds store byte-enables, and stalls the pipeline while an access is in flight.
- Registered load data, done and error flags feed the M/W register.

Parameters:
- TIMEOUT, 255: maximum cycles spent in RESP waiting for dmem_rvalid_i before bus error; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2**TO_W.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid_M_i  in  1  an instruction is present in M
- flush_i  in  1  kill the M instruction before it starts
- aludata_M_i  in  32  effective byte address
- rs2data_M_i  in  32  store data
- wren_M_i  in  1  1 = store, 0 = load
- lsop_M_i  in  4  [1:0] size (00 B, 01 H, 10 W, 11 illegal); [2] memory access; [3] reserved, ignored
- lsuns_M_i  in  1  load zero-extend when 1, sign-extend when 0
- dmem_req_o  out  1  request valid
- dmem_we_o  out  1  write request
- dmem_addr_o  out  32  word address {addr[31:2],2'b00}
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_be_o  out  4  byte enables (stores); 4'b1111 on loads
- dmem_ready_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  32  load word
- stall_o  out  1  hold upstream stages
- lddata_o  out  32  aligned, extended load result
- done_o  out  1  one-cycle completion pulse
- misalign_o  out  1  misaligned or illegal access; sticky until the next start
- buserr_o  out  1  response timeout; sticky until the next start

Behaviour:
- Start condition: state==IDLE & valid_M_i & lsop_M_i[2] & ~flush_i. On start, address, data, op, unsigned flag and store enable are latched internally; inputs are not reused afterwards.
- Misalignment is detected at start: H with addr[0]=1, W with addr[1:0]!=0, or size 11.
- stall_o = start | state in {REQ, RESP}. stall_o is combinational, and it is low in DONE so the pipeline advances at the end of the DONE cycle.
- State machine transitions:
  - IDLE -> DONE on a misaligned start: set misalign_o, no memory request.
  - IDLE -> REQ on an aligned start: clear misalign_o and buserr_o.
  - REQ: dmem_req_o=1, with we/addr/wdata/be held stable until dmem_ready_i. On ready, a store goes to DONE and a load goes to RESP with the timeout counter cleared.
  - RESP: on dmem_rvalid_i, write the formatted data to lddata_o and go to DONE. Otherwise the counter increments. When the counter reaches TIMEOUT (TIMEOUT != 0), set buserr_o, set lddata_o=0, and go to DONE.
  - DONE: done_o=1 for one cycle, then go to IDLE. DONE never re-starts, because the completed instruction is still in M during DONE.
- Store formatting:
  - B: wdata={4{d[7:0]}}, be=4'b0001<<off
  - H: wdata={2{d[15:0]}}, be=4'b0011<<off
  - W: wdata=d, be=4'b1111
- Load formatting:
  - B selects byte rdata[8*off+:8].
  - H selects rdata[16*off[1]+:16].
  - B and H are then sign- or zero-extended per lsuns.
- Store done: lddata_o unchanged.
- Minimum latency, counted from the start cycle to the DONE cycle inclusive: store 3 cycles, load 4 cycles.
- Simultaneous dmem_ready_i and dmem_rvalid_i in REQ: rvalid is ignored. A response is only valid in RESP.
- dmem_rvalid_i outside RESP is ignored.
- flush_i is honoured only in IDLE; once REQ is entered the access completes.
- Reset (asynchronous, any state, including mid-transaction): state=IDLE; all outputs 0 (stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, lddata_o, done_o, misalign_o, buserr_o); counter 0.

Test Plan:
- Store byte: addr=0x103, d=0x000000A5, ready on first REQ cycle -> be=1000, wdata=0xA5A5A5A5, addr_o=0x100, stall high 2 cycles, done on cycle 3.
- Load half signed: addr=0x202, rdata=0x8001xxxx, lsuns=0, rvalid 2 cycles after accept -> lddata_o=0xFFFF8001, done after RESP.
- Load byte unsigned: addr=0x001, rdata=0x0000F000 -> lddata_o=0x000000F0; with lsuns=0 -> 0xFFFFFFF0.
- Misaligned word: addr=0x006, W -> no dmem_req_o, misalign_o=1, done_o on the cycle after start; size 11 gives the same response.
- Timeout: TIMEOUT=4, load accepted, rvalid never asserted -> buserr_o=1 and lddata_o=0 after 4 RESP cycles; a following clean access clears buserr_o.
- Reset during RESP and flush_i at start: rst_i mid-wait -> all outputs 0 immediately, IDLE; flush_i=1 with a valid access -> no stall, no request.
